// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous-read data-memory port between two memory-stage lanes.
// Defining DMEM_ARB_STAT_EN adds a collision counter and a registered stall flag.
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  l0_req,
  input  logic                  l0_we,
  input  logic [DATA_W/8-1:0]   l0_wea,
  input  logic [ADDR_W-1:0]     l0_addr,
  input  logic [DATA_W-1:0]     l0_wdata,
  input  logic                  l0_num,
  input  logic                  l1_req,
  input  logic                  l1_we,
  input  logic [DATA_W/8-1:0]   l1_wea,
  input  logic [ADDR_W-1:0]     l1_addr,
  input  logic [DATA_W-1:0]     l1_wdata,
  input  logic                  l1_num,
  output logic                  stall,
  output logic                  l0_rvalid,
  output logic [DATA_W-1:0]     l0_rdata,
  output logic                  l1_rvalid,
  output logic [DATA_W-1:0]     l1_rdata,
  output logic                  mem_en,
  output logic                  mem_w,
  output logic [DATA_W/8-1:0]   mem_wea,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
`ifdef DMEM_ARB_STAT_EN
  output logic [31:0]           conflict_cnt,
  output logic                  stall_active,
`endif
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {S_IDLE, S_SECOND} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_hold_we;
  logic [STRB_W-1:0]   r_hold_wea;
  logic [ADDR_W-1:0]   r_hold_addr;
  logic [DATA_W-1:0]   r_hold_wdata;
  logic                r_hold_lane;

  logic [ADDR_W-1:0]   r_last_addr;
  logic [DATA_W-1:0]   r_last_wdata;
  logic                r_pend_vld;
  logic                r_pend_lane;
  logic [DATA_W-1:0]   r_l0_rdata;
  logic [DATA_W-1:0]   r_l1_rdata;

  logic                w_l1_older;
  logic                w_sel_l1;
  logic                w_in_we;
  logic [STRB_W-1:0]   w_in_wea;
  logic [ADDR_W-1:0]   w_in_addr;
  logic [DATA_W-1:0]   w_in_wdata;

  logic                w_issue;
  logic                w_we;
  logic [STRB_W-1:0]   w_wea;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_lane;
  logic                w_latch;

  // Lane 1 is older only when its tag is 0 and lane 0's is 1; ties go to lane 0.
  always_comb begin
    w_l1_older = l0_num & ~l1_num;
    w_sel_l1   = (l0_req & l1_req) ? w_l1_older : ~l0_req;
    w_in_we    = w_sel_l1 ? l1_we    : l0_we;
    w_in_wea   = w_sel_l1 ? l1_wea   : l0_wea;
    w_in_addr  = w_sel_l1 ? l1_addr  : l0_addr;
    w_in_wdata = w_sel_l1 ? l1_wdata : l0_wdata;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_we        = 1'b0;
    w_wea       = '0;
    w_addr      = r_last_addr;
    w_wdata     = r_last_wdata;
    w_lane      = 1'b0;
    w_latch     = 1'b0;
    stall       = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (l0_req | l1_req) begin
            w_issue = 1'b1;
            w_we    = w_in_we;
            w_wea   = w_in_wea;
            w_addr  = w_in_addr;
            w_wdata = w_in_wdata;
            w_lane  = w_sel_l1;
          end
          if (l0_req & l1_req) begin
            w_latch     = 1'b1;
            stall       = 1'b1;
            w_state_nxt = S_SECOND;
          end
        end
        S_SECOND: begin
          w_issue     = 1'b1;
          w_we        = r_hold_we;
          w_wea       = r_hold_wea;
          w_addr      = r_hold_addr;
          w_wdata     = r_hold_wdata;
          w_lane      = r_hold_lane;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign mem_en    = w_issue;
  assign mem_w     = w_issue & w_we;
  assign mem_wea   = (w_issue & w_we) ? w_wea : '0;
  assign mem_addr  = w_addr;
  assign mem_wdata = w_wdata;

  // Read data arrives the cycle after issue and is bypassed straight to the lane.
  assign l0_rvalid = r_pend_vld & ~r_pend_lane & ~rst;
  assign l1_rvalid = r_pend_vld &  r_pend_lane & ~rst;
  assign l0_rdata  = l0_rvalid ? mem_rdata : r_l0_rdata;
  assign l1_rdata  = l1_rvalid ? mem_rdata : r_l1_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_hold_we    <= 1'b0;
      r_hold_wea   <= '0;
      r_hold_addr  <= '0;
      r_hold_wdata <= '0;
      r_hold_lane  <= 1'b0;
      r_last_addr  <= '0;
      r_last_wdata <= '0;
      r_pend_vld   <= 1'b0;
      r_pend_lane  <= 1'b0;
      r_l0_rdata   <= '0;
      r_l1_rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_hold_we    <= w_sel_l1 ? l0_we    : l1_we;
        r_hold_wea   <= w_sel_l1 ? l0_wea   : l1_wea;
        r_hold_addr  <= w_sel_l1 ? l0_addr  : l1_addr;
        r_hold_wdata <= w_sel_l1 ? l0_wdata : l1_wdata;
        r_hold_lane  <= ~w_sel_l1;
      end
      if (w_issue) begin
        r_last_addr  <= w_addr;
        r_last_wdata <= w_wdata;
      end
      r_pend_vld  <= w_issue & ~w_we;
      r_pend_lane <= w_lane;
      if (l0_rvalid) r_l0_rdata <= mem_rdata;
      if (l1_rvalid) r_l1_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
      stall_active <= 1'b0;
    end else begin
      stall_active <= stall;
      if (w_latch && conflict_cnt != 32'hFFFF_FFFF) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a behavioural byte-strobed RAM.
// Counter checks compile in only when DMEM_ARB_STAT_EN is defined.
module tb_dmem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic        clk;
  logic        rst;
  logic        l0_req, l0_we, l0_num;
  logic [3:0]  l0_wea;
  logic [31:0] l0_addr, l0_wdata;
  logic        l1_req, l1_we, l1_num;
  logic [3:0]  l1_wea;
  logic [31:0] l1_addr, l1_wdata;
  logic        stall, l0_rvalid, l1_rvalid;
  logic [31:0] l0_rdata, l1_rdata;
  logic        mem_en, mem_w;
  logic [3:0]  mem_wea;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STAT_EN
  logic [31:0] conflict_cnt;
  logic        stall_active;
`endif

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .l0_req(l0_req), .l0_we(l0_we), .l0_wea(l0_wea), .l0_addr(l0_addr),
    .l0_wdata(l0_wdata), .l0_num(l0_num),
    .l1_req(l1_req), .l1_we(l1_we), .l1_wea(l1_wea), .l1_addr(l1_addr),
    .l1_wdata(l1_wdata), .l1_num(l1_num),
    .stall(stall),
    .l0_rvalid(l0_rvalid), .l0_rdata(l0_rdata),
    .l1_rvalid(l1_rvalid), .l1_rdata(l1_rdata),
    .mem_en(mem_en), .mem_w(mem_w), .mem_wea(mem_wea),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef DMEM_ARB_STAT_EN
    .conflict_cnt(conflict_cnt), .stall_active(stall_active),
`endif
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       init_word = 32'h1111_1111;
      1:       init_word = 32'h2222_2222;
      4:       init_word = 32'hDEAD_BEEF;
      8:       init_word = 32'hAABB_CC00;
      default: init_word = 32'hC0DE_0000 | i;
    endcase
  endfunction

  // Behavioural RAM: byte-strobed write, registered read.
  logic [31:0] ram [0:255];
  logic        ram_load;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_w) begin
        for (int b = 0; b < 4; b++)
          if (mem_wea[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[9:2]];
      end
    end
  end

  // Program-order reference memory, updated as stimulus is driven.
  logic [31:0] model [0:255];

  typedef struct {
    logic        lane;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  task automatic model_write(input logic [31:0] addr, input logic [3:0] wea, input logic [31:0] wd);
    for (int b = 0; b < 4; b++)
      if (wea[b]) model[addr[9:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic exp_read(input logic lane, input logic [31:0] addr);
    exp_t e;
    e.lane = lane;
    e.data = model[addr[9:2]];
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (l0_rvalid || l1_rvalid) begin
      if (l0_rvalid && l1_rvalid) chk("rvalid_both", 1, 0);
      if (sbq.size() == 0) begin
        chk("rvalid_unexpected", {l1_rvalid, l0_rvalid}, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("ret_lane", l1_rvalid, mon_e.lane);
        chk("ret_rdata", mon_e.lane ? l1_rdata : l0_rdata, mon_e.data);
      end
    end
  end

  task automatic set_lane(input int ln, input logic req, input logic we, input logic [3:0] wea,
                          input logic [31:0] addr, input logic [31:0] wd, input logic num);
    if (ln == 0) begin
      l0_req = req; l0_we = we; l0_wea = wea; l0_addr = addr; l0_wdata = wd; l0_num = num;
    end else begin
      l1_req = req; l1_we = we; l1_wea = wea; l1_addr = addr; l1_wdata = wd; l1_num = num;
    end
  endtask

  task automatic idle_inputs();
    l0_req = 1'b0; l1_req = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ram_load = 1'b1;
    rst = 1'b1;
    set_lane(0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    set_lane(1, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 256; i++) model[i] = init_word(i);
    repeat (2) @(posedge clk);
    #1;
    ram_load = 1'b0;

    // Reset with a live request: everything suppressed.
    set_lane(0, 1, 0, 4'h0, 32'h10, 32'h0, 0);
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rvalid", {l1_rvalid, l0_rvalid}, 0);
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("post_rst_addr", mem_addr, 0);
    chk("post_rst_wdata", mem_wdata, 0);
    chk("post_rst_rdata0", l0_rdata, 0);
    chk("post_rst_rdata1", l1_rdata, 0);
    chk("idle_mem_en", mem_en, 0);
    chk("idle_wea", mem_wea, 0);

    // Single read on lane 0.
    next_cycle();
    set_lane(0, 1, 0, 4'hF, 32'h10, 32'h0, 0);
    exp_read(0, 32'h10);
    @(negedge clk);
    chk("t1_en", mem_en, 1);
    chk("t1_stall", stall, 0);
    chk("t1_addr", mem_addr, 32'h10);
    chk("t1_wea", mem_wea, 0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("t1_l0_rvalid", l0_rvalid, 1);
    chk("t1_l1_rvalid", l1_rvalid, 0);
    chk("t1_addr_hold", mem_addr, 32'h10);

    // Collision, lane 1 older: byte write then read of the same word.
    next_cycle();
    set_lane(1, 1, 1, 4'b0001, 32'h20, 32'h55, 0);
    set_lane(0, 1, 0, 4'h0, 32'h20, 32'h0, 1);
    model_write(32'h20, 4'b0001, 32'h55);
    exp_read(0, 32'h20);
    @(negedge clk);
    chk("t2_c0_stall", stall, 1);
    chk("t2_c0_w", mem_w, 1);
    chk("t2_c0_addr", mem_addr, 32'h20);
    chk("t2_c0_wea", mem_wea, 4'b0001);
    chk("t2_c0_wdata", mem_wdata, 32'h55);
    next_cycle();
    @(negedge clk);
    chk("t2_c1_stall", stall, 0);
    chk("t2_c1_en", mem_en, 1);
    chk("t2_c1_w", mem_w, 0);
    chk("t2_c1_addr", mem_addr, 32'h20);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("t2_c2_rvalid", l0_rvalid, 1);

    // Collision, equal tags: lane 0 goes first.
    next_cycle();
    set_lane(0, 1, 0, 4'h0, 32'h0, 32'h0, 0);
    set_lane(1, 1, 0, 4'h0, 32'h4, 32'h0, 0);
    exp_read(0, 32'h0);
    exp_read(1, 32'h4);
    @(negedge clk);
    chk("t3_c0_stall", stall, 1);
    chk("t3_c0_addr", mem_addr, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("t3_c1_stall", stall, 0);
    chk("t3_c1_addr", mem_addr, 32'h4);
    chk("t3_c1_l0_rvalid", l0_rvalid, 1);
`ifdef DMEM_ARB_STAT_EN
    chk("t3_stall_active", stall_active, 1);
`endif
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("t3_c2_l1_rvalid", l1_rvalid, 1);
    chk("t3_c2_l0_rvalid", l0_rvalid, 0);
    chk("t3_l0_sticky", l0_rdata, 32'h1111_1111);
`ifdef DMEM_ARB_STAT_EN
    chk("cnt_two", conflict_cnt, 2);
`endif

    // Reset during SECOND: held write discarded, pending read dropped.
    next_cycle();
    set_lane(0, 1, 0, 4'h0, 32'h10, 32'h0, 0);
    set_lane(1, 1, 1, 4'hF, 32'h30, 32'hBAD0_BAD0, 1);
    @(negedge clk);
    chk("t4_c0_stall", stall, 1);
    chk("t4_c0_addr", mem_addr, 32'h10);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_en", mem_en, 0);
    chk("t4_rst_stall", stall, 0);
    chk("t4_rst_rvalid", {l1_rvalid, l0_rvalid}, 0);
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("t4_after_en", mem_en, 0);
    chk("t4_after_stall", stall, 0);
    chk("t4_after_addr", mem_addr, 0);
    chk("t4_after_rdata0", l0_rdata, 0);
    chk("t4_after_rvalid", {l1_rvalid, l0_rvalid}, 0);
    chk("t4_no_write", ram[12], model[12]);
`ifdef DMEM_ARB_STAT_EN
    chk("cnt_cleared", conflict_cnt, 0);
`endif
    next_cycle();
    set_lane(1, 1, 0, 4'h0, 32'h30, 32'h0, 0);
    exp_read(1, 32'h30);
    @(negedge clk);
    chk("t4_idle_stall", stall, 0);
    chk("t4_idle_addr", mem_addr, 32'h30);

    // Alternating single accesses, one of them a read.
    for (int i = 0; i < 8; i++) begin
      logic [3:0]  wea;
      logic [31:0] wd;
      logic        we;
      logic [31:0] addr;
      next_cycle();
      we   = (i != 5);
      wea  = 4'($urandom_range(1, 15));
      wd   = $urandom;
      addr = 32'h40 + 32'(4 * i);
      set_lane(i % 2, 1, we, wea, addr, wd, 1'($urandom_range(0, 1)));
      set_lane(1 - (i % 2), 0, 1, 4'hF, $urandom, $urandom, 1'($urandom_range(0, 1)));
      if (we) model_write(addr, wea, wd);
      else    exp_read(1'(i % 2), addr);
      @(negedge clk);
      chk("t5_stall", stall, 0);
      chk("t5_w", mem_w, we);
      chk("t5_wea", mem_wea, we ? wea : 4'h0);
      chk("t5_addr", mem_addr, addr);
      chk("t5_wdata", mem_wdata, wd);
    end
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      set_lane(i % 2, 1, 0, 4'hF, 32'h40 + 32'(4 * i), 32'h0, 0);
      set_lane(1 - (i % 2), 0, 0, 4'h0, 32'h0, 32'h0, 0);
      exp_read(1'(i % 2), 32'h40 + 32'(4 * i));
      @(negedge clk);
      chk("t5_rd_en", mem_en, 1);
    end
    next_cycle();
    idle_inputs();

    // Three collisions, then reset.
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      set_lane(0, 1, 0, 4'h0, 32'h40 + 32'(4 * k), 32'h0, 1);
      set_lane(1, 1, 0, 4'h0, 32'h50 + 32'(4 * k), 32'h0, 0);
      exp_read(1, 32'h50 + 32'(4 * k));
      exp_read(0, 32'h40 + 32'(4 * k));
      @(negedge clk);
      chk("t6_stall", stall, 1);
      chk("t6_first_addr", mem_addr, 32'h50 + 32'(4 * k));
      next_cycle();
      @(negedge clk);
      chk("t6_second_addr", mem_addr, 32'h40 + 32'(4 * k));
    end
    next_cycle();
    idle_inputs();
    next_cycle();
`ifdef DMEM_ARB_STAT_EN
    chk("cnt_three", conflict_cnt, 3);
`endif
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
`ifdef DMEM_ARB_STAT_EN
    chk("cnt_reset", conflict_cnt, 0);
`endif
    chk("end_stall", stall, 0);
    repeat (2) next_cycle();
    chk("sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
